md_sched: RTL

- Execute-stage multiply/divide controller for the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and holds the HI/LO registers.
- Models a multi-cycle unit with a busy counter.
- Raises a stall request so hazard control freezes F/D and bubbles E while a D-stage HI/LO instruction would collide with an active operation.

---
 rtl/md_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// Execute-stage multiply/divide controller: owns HI/LO, models a multi-cycle
// unit with a down-counter and requests a pipeline stall on HI/LO hazards.
//
// state | meaning
// IDLE  | no operation in flight; mult/div may start, mthi/mtlo write directly
// RUN   | counter counting down; pending result commits when counter hits 1
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_src_a,
  input  logic [31:0] e_src_b,
  input  logic        d_md_use,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] e_md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [0:0]      state;
  logic [CntW-1:0] counter;
  logic [31:0]     pendingHi;
  logic [31:0]     pendingLo;
  logic            pendingWrite;

  logic            isDiv;
  logic            divByZero;
  logic            signedOvf;
  logic [63:0]     prodS;
  logic [63:0]     prodU;
  logic [31:0]     sDivisor;
  logic [31:0]     uDivisor;
  logic [31:0]     quotS;
  logic [31:0]     remS;
  logic [31:0]     quotU;
  logic [31:0]     remU;
  logic [31:0]     resHi;
  logic [31:0]     resLo;

  assign busy     = (state == RUN);
  assign start    = (e_md_op >= OP_MULT) && (e_md_op <= OP_DIVU) && !busy;
  assign md_stall = d_md_use & (start | busy);
  assign isDiv    = (e_md_op == OP_DIV) || (e_md_op == OP_DIVU);

  assign e_md_rdata = (e_md_op == OP_MFHI) ? hi :
                      (e_md_op == OP_MFLO) ? lo : 32'd0;

  assign prodS = $signed({{32{e_src_a[31]}}, e_src_a}) * $signed({{32{e_src_b[31]}}, e_src_b});
  assign prodU = {32'd0, e_src_a} * {32'd0, e_src_b};

  // Dividing by 1 in the overflow case yields exactly 0x80000000 rem 0, and
  // a zero divisor is swapped for 1 so the datapath never sees x/0.
  assign divByZero = (e_src_b == 32'd0);
  assign signedOvf = (e_src_a == 32'h8000_0000) && (e_src_b == 32'hFFFF_FFFF);
  assign sDivisor  = (divByZero || signedOvf) ? 32'd1 : e_src_b;
  assign uDivisor  = divByZero ? 32'd1 : e_src_b;

  assign quotS = $signed(e_src_a) / $signed(sDivisor);
  assign remS  = $signed(e_src_a) % $signed(sDivisor);
  assign quotU = e_src_a / uDivisor;
  assign remU  = e_src_a % uDivisor;

  always_comb begin
    resHi = 32'd0;
    resLo = 32'd0;
    case (e_md_op)
      OP_MULT:  {resHi, resLo} = prodS;
      OP_MULTU: {resHi, resLo} = prodU;
      OP_DIV:   begin resHi = remS; resLo = quotS; end
      OP_DIVU:  begin resHi = remU; resLo = quotU; end
      default:  begin resHi = 32'd0; resLo = 32'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      hi           <= 32'd0;
      lo           <= 32'd0;
      pendingHi    <= 32'd0;
      pendingLo    <= 32'd0;
      pendingWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            counter      <= isDiv ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            pendingHi    <= resHi;
            pendingLo    <= resLo;
            pendingWrite <= !(isDiv && divByZero);
          end else if (e_md_op == OP_MTHI) begin
            hi <= e_src_a;
          end else if (e_md_op == OP_MTLO) begin
            lo <= e_src_a;
          end
        end
        RUN: begin
          // Ops arriving here are a stall failure and are deliberately ignored.
          if (counter == CntW'(1)) begin
            state   <= IDLE;
            counter <= '0;
            if (pendingWrite) begin
              hi <= pendingHi;
              lo <= pendingLo;
            end
          end else begin
            counter <= counter - CntW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule
